// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Brief    : Shared state encodings and key codes for the keypad lock.
// Revision : 1.0
// ============================================================================
package lock_pkg;

    typedef logic [2:0] lock_state_t;

    // Encodings are shared with the RGB, seven-segment and buzzer blocks.
    localparam lock_state_t ST_WAIT   = 3'b000;
    localparam lock_state_t ST_INPUT  = 3'b001;
    localparam lock_state_t ST_UNLOCK = 3'b010;
    localparam lock_state_t ST_ERROR  = 3'b011;
    localparam lock_state_t ST_ALARM  = 3'b100;
    localparam lock_state_t ST_ADMIN  = 3'b101;

    localparam logic [3:0] KEY_CONFIRM = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer
// Brief    : Shared 32-bit dwell/timeout counter with terminal-count strobe.
// Revision : 1.0
// ============================================================================
module lock_timer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLEAR,
    input  logic        ENABLE,
    input  logic [31:0] TERM_CNT,
    output logic        DONE
);

    logic [31:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST || CLEAR) begin
            r_count <= 32'd0;
        end else if (ENABLE) begin
            r_count <= r_count + 32'd1;
        end
    end

    // The owner clears the counter on the same edge DONE is acted on, so it pulses once.
    assign DONE = ENABLE && (r_count == TERM_CNT);

endmodule
`default_nettype wire

// File: rtl/lock_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lock_state_ctrl
// Brief    : Keypad lock state controller: password buffer, attempt counter,
//            dwell/timeout sequencing.
// Revision : 1.0
// ============================================================================
module lock_state_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned             PWD_LEN     = 4,
    parameter logic [4*PWD_LEN-1:0]    DEFAULT_PWD = 16'h1234,
    parameter logic [4*PWD_LEN-1:0]    ADMIN_PWD   = 16'h9999,
    parameter int unsigned             MAX_ERR     = 3,
    parameter int unsigned             INPUT_TO    = 500_000_000,
    parameter int unsigned             UNLOCK_CYC  = 300_000_000,
    parameter int unsigned             ERROR_CYC   = 100_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_CODE,
    output logic [2:0] Current_State,
    output logic [2:0] DIGIT_CNT,
    output logic [1:0] ERR_CNT,
    output logic       UNLOCK,
    output logic       ALARM_OUT
);

    localparam int unsigned BUF_W = 4 * PWD_LEN;

    lock_state_t       r_state;
    logic [BUF_W-1:0]  r_buf;
    logic [2:0]        r_cnt;
    logic [1:0]        r_err;
    logic [BUF_W-1:0]  r_pwd;
    logic              r_unlock;
    logic              r_alarm;

    lock_state_t       w_state_nxt;
    logic [BUF_W-1:0]  w_buf_nxt;
    logic [2:0]        w_cnt_nxt;
    logic [1:0]        w_err_nxt;
    logic [BUF_W-1:0]  w_pwd_nxt;
    logic              w_key_acc;
    logic              w_is_digit;
    logic              w_is_conf;
    logic              w_is_clr;
    logic              w_full;
    logic              w_digit_take;
    logic [BUF_W-1:0]  w_buf_shift;
    logic [1:0]        w_err_inc;
    logic              w_timer_en;
    logic              w_timer_clr;
    logic [31:0]       w_term;
    logic              w_done;

    always_comb begin
        w_is_digit   = KEY_VALID && is_digit(KEY_CODE);
        w_is_conf    = KEY_VALID && (KEY_CODE == KEY_CONFIRM);
        w_is_clr     = KEY_VALID && (KEY_CODE == KEY_CLEAR);
        w_full       = (r_cnt == 3'(PWD_LEN));
        w_digit_take = w_is_digit && !w_full;
        w_buf_shift  = {r_buf[BUF_W-5:0], KEY_CODE};
        w_err_inc    = (r_err == 2'(MAX_ERR)) ? r_err : (r_err + 2'd1);
    end

    always_comb begin
        w_timer_en = 1'b0;
        w_term     = 32'd0;
        case (r_state)
            ST_INPUT, ST_ADMIN: begin
                w_timer_en = 1'b1;
                w_term     = 32'(INPUT_TO - 1);
            end
            ST_UNLOCK: begin
                w_timer_en = 1'b1;
                w_term     = 32'(UNLOCK_CYC - 1);
            end
            ST_ERROR: begin
                w_timer_en = 1'b1;
                w_term     = 32'(ERROR_CYC - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_pwd_nxt   = r_pwd;
        w_key_acc   = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_is_digit) begin
                    w_state_nxt = ST_INPUT;
                    w_buf_nxt   = BUF_W'(KEY_CODE);
                    w_cnt_nxt   = 3'd1;
                    w_key_acc   = 1'b1;
                end
            end
            ST_INPUT: begin
                if (w_digit_take) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = r_cnt + 3'd1;
                    w_key_acc = 1'b1;
                end else if (w_is_conf) begin
                    w_key_acc = 1'b1;
                    w_buf_nxt = '0;
                    w_cnt_nxt = 3'd0;
                    if (!w_full) begin
                        w_state_nxt = ST_ERROR;
                        w_err_nxt   = w_err_inc;
                    end else if (r_buf == r_pwd) begin
                        w_state_nxt = ST_UNLOCK;
                        w_err_nxt   = 2'd0;
                    end else if (r_buf == ADMIN_PWD) begin
                        w_state_nxt = ST_ADMIN;
                        w_err_nxt   = 2'd0;
                    end else begin
                        w_err_nxt   = w_err_inc;
                        w_state_nxt = (w_err_inc == 2'(MAX_ERR)) ? ST_ALARM : ST_ERROR;
                    end
                end else if (w_is_clr) begin
                    w_key_acc = 1'b1;
                    w_buf_nxt = '0;
                    w_cnt_nxt = 3'd0;
                end else if (w_done) begin
                    w_state_nxt = ST_WAIT;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = 3'd0;
                end
            end
            ST_UNLOCK, ST_ERROR: begin
                if (w_done) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ALARM: begin
                if (w_digit_take) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = r_cnt + 3'd1;
                    w_key_acc = 1'b1;
                end else if (w_is_conf || w_is_clr) begin
                    w_key_acc = 1'b1;
                    w_buf_nxt = '0;
                    w_cnt_nxt = 3'd0;
                    if (w_is_conf && w_full && (r_buf == ADMIN_PWD)) begin
                        w_state_nxt = ST_ADMIN;
                        w_err_nxt   = 2'd0;
                    end
                end
            end
            ST_ADMIN: begin
                if (w_digit_take) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = r_cnt + 3'd1;
                    w_key_acc = 1'b1;
                end else if ((w_is_conf && w_full) || w_is_clr) begin
                    w_key_acc   = 1'b1;
                    w_state_nxt = ST_WAIT;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = 3'd0;
                    if (w_is_conf) begin
                        w_pwd_nxt = r_buf;
                    end
                end else if (w_done) begin
                    w_state_nxt = ST_WAIT;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_buf_nxt   = '0;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    assign w_timer_clr = w_key_acc || (w_state_nxt != r_state);

    lock_timer u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .CLEAR    (w_timer_clr),
        .ENABLE   (w_timer_en),
        .TERM_CNT (w_term),
        .DONE     (w_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_WAIT;
            r_buf    <= '0;
            r_cnt    <= 3'd0;
            r_err    <= 2'd0;
            r_pwd    <= DEFAULT_PWD;
            r_unlock <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_buf    <= w_buf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_pwd    <= w_pwd_nxt;
            r_unlock <= (w_state_nxt == ST_UNLOCK);
            r_alarm  <= (w_state_nxt == ST_ALARM);
        end
    end

    assign Current_State = r_state;
    assign DIGIT_CNT     = r_cnt;
    assign ERR_CNT       = r_err;
    assign UNLOCK        = r_unlock;
    assign ALARM_OUT     = r_alarm;

endmodule
`default_nettype wire

// File: doc/lock_state_ctrl.md
# lock_state_ctrl

Main state controller for the keypad password lock. It consumes debounced keypad events and sequences the lock through WAIT, INPUT, UNLOCK, ERROR, ALARM and ADMIN. It drives the 3-bit `Current_State` bus that feeds the RGB indicator and the other display blocks. It also owns the user password register, the wrong-attempt counter and all dwell and timeout timers.

## Interface
Parameters:
- `PWD_LEN`, 4: digits per password (buffer is 4·PWD_LEN bits, BCD nibbles).
- `DEFAULT_PWD`, 16'h1234: user password loaded at reset.
- `ADMIN_PWD`, 16'h9999: fixed administrator password.
- `MAX_ERR`, 3: wrong attempts that trigger ALARM.
- `INPUT_TO`, 500_000_000: idle cycles before INPUT or ADMIN abandons to WAIT.
- `UNLOCK_CYC`, 300_000_000: dwell in UNLOCK.
- `ERROR_CYC`, 100_000_000: dwell in ERROR.

Ports:
- `CLK` in 1: system clock; the block uses only this clock.
- `RST` in 1: reset, synchronous, active-high.
- `KEY_VALID` in 1: one-cycle strobe, key event.
- `KEY_CODE` in 4: 0–9 digit, 4'hA confirm, 4'hB clear; other codes ignored.
- `Current_State` out 3: WAIT 000, INPUT 001, UNLOCK 010, ERROR 011, ALARM 100, ADMIN 101.
- `DIGIT_CNT` out 3: digits currently buffered (saturates at PWD_LEN).
- `ERR_CNT` out 2: wrong attempts since the last success or admin login.
- `UNLOCK` out 1: high exactly while in UNLOCK.
- `ALARM_OUT` out 1: high exactly while in ALARM.

## Operation
- Digit entry: accepted digit shifts into the buffer as `buf <= {buf[4·PWD_LEN-5:0], code}`. Keying 1,2,3,4 yields 16'h1234. Digits beyond PWD_LEN are ignored. Clear zeroes the buffer and DIGIT_CNT without changing state.
- WAIT: a digit → INPUT with that digit buffered. Confirm and clear are ignored.
- INPUT, on confirm (buffer and count cleared on every exit):
  - DIGIT_CNT≠PWD_LEN → ERROR, counted as a wrong attempt.
  - buf==user pwd → UNLOCK; ERR_CNT←0.
  - buf==ADMIN_PWD → ADMIN; ERR_CNT←0.
  - any other value → ERR_CNT+1. Go to ALARM if the new count equals MAX_ERR, else ERROR.
- INPUT, timeout: INPUT_TO cycles with no accepted key → WAIT. ERR_CNT is kept.
- UNLOCK and ERROR: keys ignored. After UNLOCK_CYC or ERROR_CYC cycles → WAIT.
- ALARM: stays in ALARM indefinitely and has no timeout.
  - Digits are buffered.
  - Confirm with buf==ADMIN_PWD and a full count → ADMIN, ERR_CNT←0.
  - Any other confirm clears the buffer and stays in ALARM.
- ADMIN: digits are buffered.
  - Confirm with a full count → user pwd←buf, then WAIT.
  - Confirm with a short count → ignored.
  - Clear → WAIT with the password unchanged.
  - Timeout → WAIT with the password unchanged.
- Illegal state encodings (110, 111) → WAIT on the next cycle.

## Timing
- Reset values (RST high at an edge): state WAIT, buffer 0, DIGIT_CNT 0, ERR_CNT 0, user pwd DEFAULT_PWD, timer 0, UNLOCK 0, ALARM_OUT 0.
- Reset mid-operation aborts everything, including a pending ADMIN password change. RST has priority over all events.
- Latency: a KEY_VALID sampled at edge n changes state, counters and outputs at edge n (visible in cycle n+1). All outputs are registered.
- Timer:
  - Clears on every state change and on every accepted key.
  - Increments otherwise.
  - A dwell or timeout of N cycles fires when timer==N-1, so the state leaves exactly N cycles after entry or after the last key.
- Simultaneous KEY_VALID and timer expiry in INPUT or ADMIN: the key wins and the timer restarts. In UNLOCK and ERROR, expiry wins and the key is dropped.
- ERR_CNT saturates at MAX_ERR and never wraps.

## Structure
- Package `lock_pkg` holds:
  - the state encodings (shared with the RGB, seven-segment and buzzer blocks),
  - the key codes `KEY_CONFIRM`/`KEY_CLEAR`,
  - a `lock_state_t` 3-bit typedef.
- Sub-module `lock_timer`:
  - ports: clear, enable, terminal-count input, one-cycle `done`;
  - 32-bit counter;
  - instantiated once and reused for all dwells and timeouts.

## Test plan
Bench parameters: INPUT_TO=20, UNLOCK_CYC=8, ERROR_CYC=5.
- Keys 1,2,3,4,A after reset → state 001 after the first key. 010 one cycle after A. UNLOCK high for 8 cycles, then 000.
- Three wrong 4-digit codes (5,5,5,5,A ×3) → ERR_CNT 1, then 2, each followed by 011 for 5 cycles. The third attempt → 100 with ALARM_OUT=1, and the state holds for more than 100 cycles.
- In ALARM, 1,2,3,4,A → stays 100 with buffer cleared. Then 9,9,9,9,A → 101 with ERR_CNT 0.
- In ADMIN, 7,7,0,1,A → 000. Then 1,2,3,4,A → ERROR. Then 7,7,0,1,A → UNLOCK.
- One digit, then no keys → 000 exactly 20 cycles after the key. A key on cycle 19 restarts the count.
- RST asserted mid-ADMIN after 7,7 → 000, DIGIT_CNT 0, and password 1234 still unlocks.
